// File: rtl/zero_flag_arb.sv
// Two-requester round-robin arbiter in front of one shared WIDTH-bit zero detector.
// Results come back one cycle after the grant; requester 0 may update the Z flag.
module zero_flag_arb #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             setf0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic             rzero,
    output logic             z_flag,
    output logic             busy
);

    logic             r_lp;
    logic             r_rvalid0;
    logic             r_rvalid1;
    logic             r_rzero;
    logic             r_zflag;
    logic             r_busy;
    logic             r_setf;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_any_gnt;
    logic [WIDTH-1:0] w_operand;
    logic             w_is_zero;

    // r_lp holds the port served last; under contention the other port wins.
    assign w_gnt0    = req0 & (~req1 | r_lp);
    assign w_gnt1    = req1 & (~req0 | ~r_lp);
    assign w_any_gnt = w_gnt0 | w_gnt1;

    assign w_operand = w_gnt1 ? data1 : data0;
    assign w_is_zero = ~|w_operand;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lp      <= 1'b1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rzero   <= 1'b0;
            r_zflag   <= 1'b0;
            r_busy    <= 1'b0;
            r_setf    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_rvalid0 <= w_gnt0;
            r_rvalid1 <= w_gnt1;
            r_busy    <= w_any_gnt;
            if (w_any_gnt) begin
                r_rzero <= w_is_zero;
                r_lp    <= w_gnt1;
            end
            if (w_gnt0) begin
                r_setf <= setf0;
            end
            // r_setf is fresh whenever r_rvalid0 is high: the previous grant went to port 0.
            if (r_rvalid0 && r_setf) begin
                r_zflag <= r_rzero;
            end
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rzero   = r_rzero;
    assign z_flag  = r_zflag;
    assign busy    = r_busy;

endmodule
